// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART framing definitions for the transmit and receive paths
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - oversample tick generator, one tick every DVSR clk cycles
module baud_tick_gen #(
  parameter int DVSR   = 163,
  parameter int DVSR_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_s_tick
);

  localparam logic [DVSR_W-1:0] CNT_LAST = DVSR_W'(DVSR - 1);

  logic [DVSR_W-1:0] r_cnt;
  logic              w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Gated by clear so a DVSR of 1 does not tick while the caller holds the phase.
  assign o_s_tick = !i_clear && w_wrap;

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop period
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam int TICK_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [2:0]        DBIT_LAST = 3'(DBIT - 1);
  localparam logic [7:0]        DATA_MASK = 8'((1 << DBIT) - 1);
  localparam logic              PAR_INV   = (PARITY == PAR_ODD);

  uart_state_e       r_state, w_state_next;
  logic [TICK_W-1:0] r_tick,  w_tick_next;
  logic [2:0]        r_nbit,  w_nbit_next;
  logic [7:0]        r_shift, w_shift_next;
  logic              r_par,   w_par_next;
  logic              r_tx,    w_tx_next;
  logic              r_busy;
  logic              w_done;
  logic              w_s_tick;
  logic [7:0]        w_din_masked;

  assign w_din_masked = din & DATA_MASK;

  baud_tick_gen #(
    .DVSR   (DVSR),
    .DVSR_W (DVSR_W)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_state == IDLE),
    .o_s_tick (w_s_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_nbit  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tick  <= w_tick_next;
      r_nbit  <= w_nbit_next;
      r_shift <= w_shift_next;
      r_par   <= w_par_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_state_next != IDLE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick;
    w_nbit_next  = r_nbit;
    w_shift_next = r_shift;
    w_par_next   = r_par;
    w_done       = 1'b0;

    case (r_state)
      IDLE: begin
        if (tx_start) begin
          w_state_next = START;
          w_tick_next  = '0;
          w_nbit_next  = '0;
          w_shift_next = w_din_masked;
          // Parity is fixed at capture time because the shift register is consumed.
          w_par_next   = (^w_din_masked) ^ PAR_INV;
        end
      end

      START: begin
        if (w_s_tick) begin
          if (r_tick == BIT_LAST) begin
            w_state_next = DATA;
            w_tick_next  = '0;
            w_nbit_next  = '0;
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
      end

      DATA: begin
        if (w_s_tick) begin
          if (r_tick == BIT_LAST) begin
            w_tick_next  = '0;
            w_shift_next = {1'b0, r_shift[7:1]};
            if (r_nbit == DBIT_LAST) begin
              w_state_next = (PARITY != PAR_NONE) ? PAR : STOP;
            end else begin
              w_nbit_next = r_nbit + 1'b1;
            end
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
      end

      PAR: begin
        if (w_s_tick) begin
          if (r_tick == BIT_LAST) begin
            w_state_next = STOP;
            w_tick_next  = '0;
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
      end

      STOP: begin
        if (w_s_tick) begin
          if (r_tick == STOP_LAST) begin
            w_state_next = IDLE;
            w_tick_next  = '0;
            w_done       = 1'b1;
          end else begin
            w_tick_next = r_tick + 1'b1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
        w_tick_next  = '0;
      end
    endcase
  end

  // The line level is computed for the state being entered so tx changes on the same edge.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PAR:     w_tx_next = w_par_next;
      default: w_tx_next = 1'b1;
    endcase
  end

  assign tx           = r_tx;
  assign tx_busy      = r_busy;
  assign tx_done_tick = w_done;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed checks of uart_tx_core framing, timing, parity and reset
module tb_uart_tx_core;

  localparam int DVSR_A = 2;
  localparam int DVSR_P = 1;
  localparam int DBIT_A = 8;
  localparam int PAR_A  = 0;

  if (DBIT_A > 8 || DBIT_A < 5 || PAR_A > 2 || DVSR_A < 1 || DVSR_P < 1) begin : g_bad_params
    initial $fatal(1, "illegal uart_tx_core parameters");
  end

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start_v;
  logic [7:0] din;
  logic [2:0] tx_v, busy_v, done_v;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_core #(.DBIT(DBIT_A), .SB_TICK(16), .PARITY(PAR_A), .DVSR(DVSR_A), .DVSR_W(8)) u_dut_none (
    .clk(clk), .reset(reset), .tx_start(start_v[0]), .din(din),
    .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done_tick(done_v[0])
  );

  uart_tx_core #(.DBIT(8), .SB_TICK(16), .PARITY(1), .DVSR(DVSR_P), .DVSR_W(8)) u_dut_even (
    .clk(clk), .reset(reset), .tx_start(start_v[1]), .din(din),
    .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done_tick(done_v[1])
  );

  uart_tx_core #(.DBIT(8), .SB_TICK(16), .PARITY(2), .DVSR(DVSR_P), .DVSR_W(8)) u_dut_odd (
    .clk(clk), .reset(reset), .tx_start(start_v[2]), .din(din),
    .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done_tick(done_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_check(input int ncyc, input string tag);
    int bad;
    bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if ({tx_v, busy_v, done_v} !== {3'b111, 3'b000, 3'b000}) bad++;
    end
    chk(tag, bad, 0);
  endtask

  // Caller raises start_v[u] at a negedge; the next posedge is the acceptance edge.
  task automatic frame_check(input int u, input int dvsr, input int nbits, input logic [10:0] bits,
                             input bit hold, input logic [7:0] din_after, input int pulse_at,
                             input string tag);
    int bt, len, done_at, ndone;
    bt      = 16 * dvsr;
    len     = nbits * bt;
    done_at = -1;
    ndone   = 0;
    @(posedge clk);
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk($sformatf("%s first_cycle_tx", tag), tx_v[u], 0);
        chk($sformatf("%s first_cycle_busy", tag), busy_v[u], 1);
        if (!hold) start_v[u] = 1'b0;
        din = din_after;
      end
      if (c == pulse_at) begin
        start_v[u] = 1'b1;
        din = ~din_after;
      end
      if (c == pulse_at + 1) start_v[u] = 1'b0;
      if (done_v[u]) begin
        ndone++;
        done_at = c;
      end
      if (c <= len && ((c - 1) % bt) == bt / 2)
        chk($sformatf("%s bit%0d", tag, (c - 1) / bt), tx_v[u], bits[(c - 1) / bt]);
    end
    chk($sformatf("%s done_cycle", tag), done_at, len);
    chk($sformatf("%s done_count", tag), ndone, 1);
    chk($sformatf("%s idle_tx", tag), tx_v[u], 1);
    chk($sformatf("%s idle_busy", tag), busy_v[u], 0);
  endtask

  initial begin
    int ndone;
    reset   = 1'b0;
    start_v = 3'b000;
    din     = 8'h00;

    repeat (3) @(negedge clk);
    chk("reset_tx", tx_v, 3'b111);
    chk("reset_busy", busy_v, 3'b000);
    chk("reset_done", done_v, 3'b000);
    reset = 1'b1;
    idle_check(100, "post_reset_idle");

    din = 8'hA5;
    start_v[0] = 1'b1;
    frame_check(0, DVSR_A, 10, {1'b1, 8'hA5, 1'b0}, 1'b0, 8'hA5, -10, "a5");

    din = 8'h07;
    start_v[1] = 1'b1;
    frame_check(1, DVSR_P, 11, {1'b1, 1'b1, 8'h07, 1'b0}, 1'b0, 8'h07, -10, "even07");

    din = 8'h07;
    start_v[2] = 1'b1;
    frame_check(2, DVSR_P, 11, {1'b1, 1'b0, 8'h07, 1'b0}, 1'b0, 8'h07, -10, "odd07");

    din = 8'h55;
    start_v[0] = 1'b1;
    frame_check(0, DVSR_A, 10, {1'b1, 8'h55, 1'b0}, 1'b1, 8'h0F, -10, "b2b_first");
    frame_check(0, DVSR_A, 10, {1'b1, 8'h0F, 1'b0}, 1'b0, 8'h0F, -10, "b2b_second");
    idle_check(200, "b2b_no_extra");

    din = 8'h3C;
    start_v[0] = 1'b1;
    frame_check(0, DVSR_A, 10, {1'b1, 8'h3C, 1'b0}, 1'b0, 8'h3C, 100, "ignored_start");
    idle_check(200, "ignored_no_extra");

    din = 8'hA5;
    start_v[0] = 1'b1;
    ndone = 0;
    @(posedge clk);
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      if (c == 1) start_v[0] = 1'b0;
      if (done_v[0]) ndone++;
    end
    chk("midrst_pre_tx", tx_v[0], 0);
    chk("midrst_pre_busy", busy_v[0], 1);
    reset = 1'b0;
    #1;
    chk("midrst_tx", tx_v[0], 1);
    chk("midrst_busy", busy_v[0], 0);
    chk("midrst_done", done_v[0], 0);
    chk("midrst_no_done_before", ndone, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle_check(40, "midrst_idle_after");

    din = 8'hC3;
    start_v[0] = 1'b1;
    frame_check(0, DVSR_A, 10, {1'b1, 8'hC3, 1'b0}, 1'b0, 8'hC3, -10, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Serial UART transmitter. Serialises one byte per request into an 8N1/8E1/8O1-style frame on the tx line. Uses 16x oversampling ticks from an internal baud generator. Sits on the transmit side of the UART subsystem and is fed by the tx FIFO read port: the FIFO's not-empty flag drives tx_start, and tx_done_tick drives the FIFO read strobe. It mirrors the framing the receive path expects.

Parameters:
DBIT, 8, data bits per frame (5..8), LSB first
SB_TICK, 16, oversample ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
PARITY, 0, 0 = none, 1 = even, 2 = odd
DVSR, 163, clk cycles per oversample tick (50 MHz / (16 x 19200)); minimum 1
DVSR_W, 8, width of the baud divisor counter; must hold DVSR-1

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
tx_start  input  1  request to send din; sampled only while idle
din  input  8  byte to transmit; bits [DBIT-1:0] are used and captured on acceptance
tx  output  1  serial line, registered, idle high
tx_busy  output  1  high from the cycle after acceptance until the return to idle
tx_done_tick  output  1  one-cycle pulse on the final stop tick

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, baud counter=0, tick count=0, bit count=0, shift register=0.
- Baud generator: counter runs 0..DVSR-1; s_tick is high in the cycle the counter equals DVSR-1, then the counter wraps to 0. The counter is forced to 0 in IDLE, so every frame is phase-aligned to its acceptance. Each bit therefore lasts exactly 16*DVSR clk cycles.
- Acceptance: in IDLE with tx_start=1, on that clock edge: din is captured into the shift register, state goes to START, tx goes to 0, and tx_busy goes to 1. While not in IDLE, tx_start and din are ignored.
- START: tx=0 for 16 s_ticks, then go to DATA with bit count 0.
- DATA: tx = shift[0]. On each 16th s_tick, shift right and increment bit count. After DBIT bits, go to PARITY if PARITY!=0, otherwise go to STOP.
- PARITY: tx = XOR of the captured DBIT data bits for even parity, or its inverse for odd parity. Lasts 16 s_ticks, then go to STOP.
- STOP: tx=1 for SB_TICK s_ticks. On the final s_tick, tx_done_tick=1 for one cycle and state goes to IDLE on the same edge. tx_busy drops on the following cycle.
- Frame length: (1 + DBIT + (PARITY!=0) + SB_TICK/16) bit times. With PARITY=0 and DBIT=8, this is 10*16*DVSR clk cycles from acceptance to tx_done_tick, inclusive of the acceptance edge.
- Back-to-back: with tx_start held high, the next frame is accepted on the first IDLE cycle. That gives exactly one clk cycle of tx=1 between the last stop tick and the next start bit.
- tx is always driven from a register (no glitches). The tick counter is 4 bits for data bits; stop ticks use a counter wide enough for SB_TICK-1.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously), no tx_done_tick is issued, and the partial frame is lost.
- Illegal parameters (DBIT>8, PARITY>2, DVSR=0) are not supported. The bench checks them with an elaboration-time assertion.

Decomposition:
- Shared package uart_pkg holds: the state enumeration (IDLE, START, DATA, PAR, STOP), the parity codes PAR_NONE/PAR_EVEN/PAR_ODD, and the OVERSAMPLE=16 constant. These are shared with the receiver.
- One sub-module, baud_tick_gen, contains the DVSR counter with a clear input, outputs s_tick, and is reused by the receiver. The FSM and datapath stay in uart_tx_core.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, wait 100 cycles. Expect tx=1, tx_busy=0, tx_done_tick=0 throughout.
- Single byte, DVSR=2, PARITY=0: pulse tx_start with din=8'hA5. Expect tx sequence 0,1,0,1,0,0,1,0,1,1, each level lasting 32 clk. tx_done_tick fires exactly 320 clk after acceptance and lasts 1 cycle.
- Even/odd parity, DVSR=1: din=8'h07. With PARITY=1 the parity bit is 1; with PARITY=2 the parity bit is 0. Frame length is 11 bit times (176 clk).
- Back-to-back: hold tx_start=1 and change din from 8'h55 to 8'h0F after the first acceptance. Expect two frames separated by exactly one idle-high cycle. The second frame carries 8'h0F, and changes to din mid-frame do not alter the first frame.
- Ignored start: assert tx_start during the DATA state of frame 1. Expect no effect on frame 1 and no extra frame afterwards if tx_start is low at the IDLE cycle.
- Reset mid-frame: assert reset=0 during data bit 3. tx must be 1 in the same cycle (async) and tx_busy=0. No tx_done_tick occurs, and a new tx_start after release produces a full, correct frame.
